task_packetizer: RTL and testbench
==================================

# task_packetizer

Frames the flat word stream emitted by the task parser into NoC packets for the local router port. It sits directly downstream of the parser and consumes its credit-handshaked descriptor and task words. It prepends a three-flit header (target, size, service) to each application descriptor and each task binary, then forwards the words unchanged.

## Interface
- `FLIT_SIZE`, 32: word and flit width; must be ≥ 32.
- `SRV_DESCR`, 32'h40: service code for descriptor packets.
- `SRV_TASK`, 32'h41: service code for task packets.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `tx_i` in 1: upstream word valid.
- `credit_o` out 1: upstream may transfer; a word moves when `tx_i && credit_o`.
- `data_i` in FLIT_SIZE: upstream word.
- `eoa_i` in 1: upstream has no more applications.
- `mapper_address_i` in 16: packet target address.
- `tx_o` out 1: flit valid to router.
- `credit_i` in 1: router accepts; a flit moves when `tx_o && credit_i`.
- `data_o` out FLIT_SIZE: flit to router.
- `eoa_o` out 1: all packets sent and upstream ended.

## Operation
- Input stream, descriptor: D (descr size), hash, N (task count), N×{map, ttt}, D graph words. Payload length L = 3 + 2N + D.
- Input stream, task: text T, data Dt, bss, entry, B binary words. B = (T+Dt)>>2, with B = 0 clamped to 1. L = 4 + B.
- Packet order: one descriptor, then exactly N task packets, then the next descriptor. `tasks_left` counter, 32 bit, is loaded with N.
- Lead words (3 for descriptor, 2 for task) are captured into a register file until L is computable. The remaining lead words (bss, entry) are also captured so that replay is uniform.
- Header flits:
  - flit0 = {zero-extend, `mapper_address_i` sampled on entering HDR}.
  - flit1 = L + 1.
  - flit2 = service code.
  - Then the captured lead words, in order, then body words.
- Body words are passed through combinationally: `tx_o = tx_i`, `credit_o = credit_i`, `data_o = data_i`.
- `body_left` counter = L − lead count. It decrements per transfer; the packet ends when it hits 0 on a transfer.
- Length arithmetic is 32-bit unsigned modulo. No overflow detection.
- States:
  - IDLE: `credit_o` = 1. Word arrives → CAP. If `eoa_i` and `tasks_left` == 0 → DONE.
  - CAP: `credit_o` = 1. Captures until the lead count (4 for task, 3 for descriptor) is reached, then → HDR.
  - HDR → SIZE → SRV: each advances on `credit_i`. `credit_o` = 0.
  - LEAD: replays the captured words, each on `credit_i`. Then → BODY, or → END if `body_left` == 0.
  - BODY: pass-through until the last word, then → END.
  - END: one cycle. Updates `tasks_left`, then → IDLE.
  - DONE: terminal; `eoa_o` = 1.
- Descriptor with N = 0: the next packet is again a descriptor.
- `eoa_i` while `tasks_left` > 0: ignored until the task count is exhausted.

## Timing
- Reset values: `tx_o` = 0, `data_o` = 0, `eoa_o` = 0, `credit_o` = 1 (IDLE). Counters = 0.
- Reset mid-packet aborts with no partial flush. The next word is treated as a descriptor lead word.
- `data_o` and `tx_o` are combinational from the state and the current lead index (in BODY, from the inputs).
- Latency:
  - First word accepted to flit0 valid: 1 cycle after the last lead word is captured.
  - Header plus lead replay is 3 + lead-count flits at one per cycle under continuous credit.
  - Body throughput is 1 word/cycle.
- Stalls: `credit_i` low holds state, the index and `data_o` stable. No flit is dropped or duplicated.
- END costs one bubble cycle between packets; IDLE accepts the next word on the following cycle.

## Structure
- Package `task_packetizer_pkg`:
  - state enum `pkt_fsm_t`.
  - `pkt_kind_t` (DESCR, TASK).
  - lead-count constants `DESCR_LEAD = 3` and `TASK_LEAD = 4`.
  - header flit count `HDR_FLITS = 3`.
- One natural sub-module, `lead_capture`: a 4-entry register file with write and read indices, a clear, and a full flag for lead count reached.
- Length computation and counters stay in the top module.

## Test plan
- Descriptor D=2, N=1 (map 0x0101, ttt 0xFFFFFFFF), graph 0,1, mapper 0x0000: expect flits 0x0, 0x8, 0x40, then 2, hash, 1, 0x0101, 0xFFFFFFFF, 0, 1.
- Following task T=8, Dt=4, bss=0, entry=0x80, 3 binary words: expect 0x0, 0x8, 0x41, 8, 4, 0, 0x80, then the 3 words. `tasks_left` ends at 0.
- Same task with `credit_i` toggled every other cycle: identical flit sequence, each flit held stable while `credit_i` is low.
- Task with T=0, Dt=0: B clamped to 1. Expect size flit 6 and exactly 1 binary word accepted.
- Descriptor N=0, then `eoa_i` high: after END → DONE, `eoa_o`=1, `credit_o`=0. `eoa_i` raised during the task phase is ignored until the last task's END.
- `rst_i` asserted during BODY: next cycle `tx_o`=0, state IDLE. A fresh descriptor is then packetized correctly.

Source files
------------

// File: rtl/task_packetizer_pkg.sv
// Shared types and constants for the task packetizer: FSM states, packet kinds,
// lead-word counts and the task binary length helper.
package task_packetizer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CAP, ST_HDR, ST_SIZE, ST_SRV, ST_LEAD, ST_BODY, ST_END, ST_DONE
  } pkt_fsm_t;

  typedef enum logic {DESCR, TASK} pkt_kind_t;

  localparam int unsigned DESCR_LEAD = 3;
  localparam int unsigned TASK_LEAD  = 4;
  localparam int unsigned HDR_FLITS  = 3;
  localparam int unsigned LEAD_IDX_W = 3;

  // Binary word count of a task image: (text + data) / 4, never zero.
  function automatic logic [31:0] task_bin_words(input logic [31:0] text_len,
                                                 input logic [31:0] data_len);
    logic [31:0] words;
    words = (text_len + data_len) >> 2;
    return (words == 32'd0) ? 32'd1 : words;
  endfunction

endpackage

// File: rtl/task_packetizer_lead_capture.sv
// Four-entry store for the lead words of a packet; filled in arrival order,
// replayed in the same order after the header flits.
module lead_capture
  import task_packetizer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [W-1:0]          wr_data_i,
  input  logic                  rd_adv_i,
  input  logic [LEAD_IDX_W-1:0] lead_cnt_i,
  output logic                  full_o,
  output logic                  rd_last_o,
  output logic [W-1:0]          rd_data_o,
  output logic [W-1:0]          lead0_o,
  output logic [W-1:0]          lead1_o,
  output logic [W-1:0]          lead2_o
);

  logic [W-1:0]            mem_q [4];
  logic [LEAD_IDX_W-1:0]   wr_idx_q;
  logic [1:0]              rd_idx_q;
  logic                    wr_ok;

  assign wr_ok = wr_en_i && (wr_idx_q < lead_cnt_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      if (wr_ok)    wr_idx_q <= wr_idx_q + LEAD_IDX_W'(1);
      if (rd_adv_i) rd_idx_q <= rd_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_idx_q[1:0]] <= wr_data_i;
  end

  // Full fires on the write that completes the lead set.
  assign full_o    = wr_en_i && (wr_idx_q == lead_cnt_i - LEAD_IDX_W'(1));
  assign rd_last_o = ({1'b0, rd_idx_q} == lead_cnt_i - LEAD_IDX_W'(1));
  assign rd_data_o = mem_q[rd_idx_q];
  assign lead0_o   = mem_q[0];
  assign lead1_o   = mem_q[1];
  assign lead2_o   = mem_q[2];

endmodule

// File: rtl/task_packetizer.sv
// Frames the parser's descriptor/task word stream into NoC packets: three
// header flits, the captured lead words, then the body passed straight through.
module task_packetizer
  import task_packetizer_pkg::*;
#(
  parameter int unsigned FLIT_SIZE = 32,
  parameter logic [31:0] SRV_DESCR = 32'h40,
  parameter logic [31:0] SRV_TASK  = 32'h41
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 eoa_i,
  input  logic [15:0]          mapper_address_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 eoa_o
);

  pkt_fsm_t              state_q, state_d;
  pkt_kind_t             kind_q, kind_d;
  logic [31:0]           tasks_left_q, tasks_left_d;
  logic [31:0]           body_left_q, body_left_d;
  logic [15:0]           addr_q, addr_d;
  logic                  cap_wr, cap_clr, rd_adv, cap_full, rd_last;
  logic [LEAD_IDX_W-1:0] lead_cnt;
  logic [FLIT_SIZE-1:0]  rd_data, lead0, lead1, lead2;
  logic [31:0]           pkt_len, body_len;

  assign lead_cnt = (kind_q == TASK) ? LEAD_IDX_W'(TASK_LEAD) : LEAD_IDX_W'(DESCR_LEAD);

  lead_capture #(.W(FLIT_SIZE)) u_lead (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cap_clr),
    .wr_en_i    (cap_wr),
    .wr_data_i  (data_i),
    .rd_adv_i   (rd_adv),
    .lead_cnt_i (lead_cnt),
    .full_o     (cap_full),
    .rd_last_o  (rd_last),
    .rd_data_o  (rd_data),
    .lead0_o    (lead0),
    .lead1_o    (lead1),
    .lead2_o    (lead2)
  );

  // Payload length L from the captured lead words (32-bit modulo).
  always_comb begin
    if (kind_q == TASK) begin
      pkt_len = 32'(TASK_LEAD) + task_bin_words(lead0[31:0], lead1[31:0]);
    end else begin
      pkt_len = 32'(DESCR_LEAD) + (lead2[31:0] << 1) + lead0[31:0];
    end
    body_len = pkt_len - 32'(lead_cnt);
  end

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    tasks_left_d = tasks_left_q;
    body_left_d  = body_left_q;
    addr_d       = addr_q;
    cap_wr       = 1'b0;
    cap_clr      = 1'b0;
    rd_adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_i) begin
          cap_wr  = 1'b1;
          state_d = ST_CAP;
        end else if (eoa_i && tasks_left_q == 32'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_CAP: begin
        if (tx_i) begin
          cap_wr = 1'b1;
          if (cap_full) begin
            state_d = ST_HDR;
            addr_d  = mapper_address_i;
          end
        end
      end
      ST_HDR:  if (credit_i) state_d = ST_SIZE;
      ST_SIZE: if (credit_i) state_d = ST_SRV;
      ST_SRV: begin
        if (credit_i) begin
          state_d     = ST_LEAD;
          body_left_d = body_len;
        end
      end
      ST_LEAD: begin
        if (credit_i) begin
          rd_adv = 1'b1;
          if (rd_last) state_d = (body_left_q == 32'd0) ? ST_END : ST_BODY;
        end
      end
      ST_BODY: begin
        if (tx_i && credit_i) begin
          body_left_d = body_left_q - 32'd1;
          if (body_left_q == 32'd1) state_d = ST_END;
        end
      end
      ST_END: begin
        cap_clr = 1'b1;
        state_d = ST_IDLE;
        // A descriptor arms N task packets; the last task hands back to descriptors.
        if (kind_q == DESCR) begin
          tasks_left_d = lead2[31:0];
          if (lead2[31:0] != 32'd0) kind_d = TASK;
        end else begin
          tasks_left_d = tasks_left_q - 32'd1;
          if (tasks_left_q == 32'd1) kind_d = DESCR;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      kind_q       <= DESCR;
      tasks_left_q <= '0;
      body_left_q  <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      tasks_left_q <= tasks_left_d;
      body_left_q  <= body_left_d;
      addr_q       <= addr_d;
    end
  end

  // Router-side outputs decode the state; the body is a straight pass-through.
  always_comb begin
    credit_o = 1'b0;
    tx_o     = 1'b0;
    data_o   = '0;
    case (state_q)
      ST_IDLE, ST_CAP: credit_o = 1'b1;
      ST_HDR: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(addr_q);
      end
      ST_SIZE: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(pkt_len + 32'd1);
      end
      ST_SRV: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'((kind_q == TASK) ? SRV_TASK : SRV_DESCR);
      end
      ST_LEAD: begin
        tx_o   = 1'b1;
        data_o = rd_data;
      end
      ST_BODY: begin
        credit_o = credit_i;
        tx_o     = tx_i;
        data_o   = data_i;
      end
      default: ;
    endcase
  end

  assign eoa_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_task_packetizer.sv
// Directed bench for task_packetizer: feeds descriptor/task word streams and
// compares every emitted flit against hand-computed packets.
module tb_task_packetizer;

  logic        clk = 1'b0;
  logic        rst_i, tx_i, credit_o, eoa_i, tx_o, credit_i, eoa_o;
  logic [31:0] data_i, data_o;
  logic [15:0] mapper;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] obs_q[$];
  logic [31:0] words_q[$];
  logic [31:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          credit_toggle = 1'b0;
  bit          held_v = 1'b0;
  logic [31:0] held_d = '0;

  always #5 clk = ~clk;

  task_packetizer dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .tx_i             (tx_i),
    .credit_o         (credit_o),
    .data_i           (data_i),
    .eoa_i            (eoa_i),
    .mapper_address_i (mapper),
    .tx_o             (tx_o),
    .credit_i         (credit_i),
    .data_o           (data_o),
    .eoa_o            (eoa_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Router credit: steady high, or toggling every cycle.
  initial begin
    credit_i = 1'b1;
    forever begin
      @(negedge clk);
      credit_i = credit_toggle ? ~credit_i : 1'b1;
    end
  end

  // Flit monitor, sampled mid-low-phase; also checks flits hold during stalls.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_tx", {31'd0, tx_o}, 32'd1);
          check("stall_data", data_o, held_d);
        end
        if (tx_o && credit_i) obs_q.push_back(data_o);
        held_v = tx_o && !credit_i;
        held_d = data_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    bit ok = 1'b0;
    tx_i   = 1'b1;
    data_i = w;
    while (!ok && n < 100) begin
      #3;
      ok = credit_o;
      @(negedge clk);
      n++;
    end
    tx_i = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pkt();
    foreach (words_q[i]) send_word(words_q[i]);
  endtask

  task automatic expect_pkt(input string tag);
    int c = 0;
    while (obs_q.size() < exp_q.size() && c < 300) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("%s.count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      check($sformatf("%s[%0d]", tag, i),
            (i < obs_q.size()) ? obs_q[i] : 32'hDEADBEEF, exp_q[i]);
    end
    obs_q.delete();
  endtask

  initial begin
    rst_i = 1'b1; tx_i = 1'b0; data_i = '0; eoa_i = 1'b0; mapper = 16'h0000;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #3;
    check("rst.tx_o", {31'd0, tx_o}, 32'd0);
    check("rst.data_o", data_o, 32'd0);
    check("rst.eoa_o", {31'd0, eoa_o}, 32'd0);
    check("rst.credit_o", {31'd0, credit_o}, 32'd1);
    @(negedge clk);
    mon_en = 1'b1;

    // Descriptor D=2, N=1, then its single task.
    words_q = '{32'd2, 32'h0000ABCD, 32'd1, 32'h0101, 32'hFFFFFFFF, 32'd0, 32'd1};
    exp_q   = '{32'h0, 32'h8, 32'h40, 32'd2, 32'h0000ABCD, 32'd1, 32'h0101, 32'hFFFFFFFF,
                32'd0, 32'd1};
    send_pkt();
    expect_pkt("descrA");
    words_q = '{32'd8, 32'd4, 32'd0, 32'h80, 32'hA1, 32'hA2, 32'hA3};
    exp_q   = '{32'h0, 32'h8, 32'h41, 32'd8, 32'd4, 32'd0, 32'h80, 32'hA1, 32'hA2, 32'hA3};
    send_pkt();
    expect_pkt("taskA");

    // Descriptor N=2 with eoa_i raised early; tasks must still be framed.
    mapper  = 16'h1234;
    words_q = '{32'd0, 32'h5555AAAA, 32'd2, 32'h0202, 32'h11, 32'h0303, 32'h22};
    exp_q   = '{32'h1234, 32'h8, 32'h40, 32'd0, 32'h5555AAAA, 32'd2, 32'h0202, 32'h11,
                32'h0303, 32'h22};
    send_pkt();
    expect_pkt("descrB");
    eoa_i = 1'b1;
    credit_toggle = 1'b1;
    words_q = '{32'd8, 32'd4, 32'd0, 32'h80, 32'hA1, 32'hA2, 32'hA3};
    exp_q   = '{32'h1234, 32'h8, 32'h41, 32'd8, 32'd4, 32'd0, 32'h80, 32'hA1, 32'hA2, 32'hA3};
    send_pkt();
    expect_pkt("taskB_stall");
    credit_toggle = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    check("eoa_ignored", {31'd0, eoa_o}, 32'd0);
    check("eoa_ignored.credit", {31'd0, credit_o}, 32'd1);
    @(negedge clk);
    words_q = '{32'd0, 32'd0, 32'h10, 32'h80, 32'hB1};
    exp_q   = '{32'h1234, 32'h6, 32'h41, 32'd0, 32'd0, 32'h10, 32'h80, 32'hB1};
    send_pkt();
    expect_pkt("task_clamp");
    repeat (4) @(negedge clk);
    #3;
    check("done.eoa_o", {31'd0, eoa_o}, 32'd1);
    check("done.credit_o", {31'd0, credit_o}, 32'd0);
    check("done.tx_o", {31'd0, tx_o}, 32'd0);
    @(negedge clk);

    // After reset: two N=0 descriptors back to back, the second header-only.
    rst_i = 1'b1; eoa_i = 1'b0; mapper = 16'h0000;
    @(negedge clk);
    rst_i = 1'b0;
    words_q = '{32'd1, 32'h0000CAFE, 32'd0, 32'h77};
    exp_q   = '{32'h0, 32'h5, 32'h40, 32'd1, 32'h0000CAFE, 32'd0, 32'h77};
    send_pkt();
    expect_pkt("descrN0");
    words_q = '{32'd0, 32'h0000BEEF, 32'd0};
    exp_q   = '{32'h0, 32'h4, 32'h40, 32'd0, 32'h0000BEEF, 32'd0};
    send_pkt();
    expect_pkt("descr_empty");
    eoa_i = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    check("done2.eoa_o", {31'd0, eoa_o}, 32'd1);
    check("done2.credit_o", {31'd0, credit_o}, 32'd0);
    @(negedge clk);

    // Reset in the middle of a body, then a fresh descriptor.
    rst_i = 1'b1; eoa_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    words_q = '{32'd4, 32'h1111, 32'd0, 32'hC0, 32'hC1};
    exp_q   = '{32'h0, 32'h8, 32'h40, 32'd4, 32'h1111, 32'd0, 32'hC0, 32'hC1};
    send_pkt();
    expect_pkt("body_prefix");
    mon_en = 1'b0;
    tx_i = 1'b1; data_i = 32'hC2; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; tx_i = 1'b0;
    #3;
    check("midrst.tx_o", {31'd0, tx_o}, 32'd0);
    check("midrst.credit_o", {31'd0, credit_o}, 32'd1);
    check("midrst.eoa_o", {31'd0, eoa_o}, 32'd0);
    @(negedge clk);
    obs_q.delete();
    mon_en = 1'b1;
    mapper  = 16'h0042;
    words_q = '{32'd1, 32'h2222, 32'd0, 32'h99};
    exp_q   = '{32'h42, 32'h5, 32'h40, 32'd1, 32'h2222, 32'd0, 32'h99};
    send_pkt();
    expect_pkt("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
